// File: rtl/nand_vector_sequencer.sv
// nand_vector_sequencer
// Stimulus/check controller for the four-input NAND gate lab datapath.
// Walks vec_out through 0x0..0xF and holds each vector for HOLD_CYCLES
// clocks. On the last clock of each hold window it compares dut_y against
// ref_y. Pass/fail status accumulates so the result can drive LEDs on a board.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   start            run request, honoured only in IDLE or DONE
//   vec_out[3:0]     gate inputs {a,b,c,d}
//   dut_y[2:0]       gate outputs {e,f,g}
//   ref_y[2:0]       golden-model outputs for the current vec_out
//   busy             high while sequencing
//   done             high once the run has finished
//   pass             valid with done; high when no vector mismatched
//   err_count[4:0]   number of mismatching vectors (0..16)
//   fail_bits[2:0]   sticky OR of dut_y ^ ref_y over the sampled vectors
//   first_fail_vec   vec_out of the first mismatching vector
//   first_fail_valid first_fail_vec holds a captured vector
module nand_vector_sequencer #(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] vec_out,
    input  logic [2:0] dut_y,
    input  logic [2:0] ref_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [2:0] fail_bits,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic             launch;
    logic             sample;
    logic [2:0]       diff;
    logic             mismatch;
    logic [4:0]       err_nxt;

    assign launch   = start && (state == IDLE || state == DONE);
    assign sample   = (state == DRIVE) && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
    assign diff     = dut_y ^ ref_y;
    assign mismatch = |diff;
    // The error count saturates at 16, one count per vector.
    assign err_nxt  = (sample && mismatch && err_count != 5'd16) ? err_count + 5'd1
                                                                : err_count;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (sample && vec_out == 4'hF) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = DRIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec_out          <= 4'h0;
            hold_cnt         <= '0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            fail_bits        <= 3'b000;
            first_fail_vec   <= 4'h0;
            first_fail_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                vec_out          <= 4'h0;
                hold_cnt         <= '0;
                pass             <= 1'b0;
                err_count        <= 5'd0;
                fail_bits        <= 3'b000;
                first_fail_vec   <= 4'h0;
                first_fail_valid <= 1'b0;
            end else if (state == DRIVE) begin
                if (sample) begin
                    hold_cnt  <= '0;
                    err_count <= err_nxt;
                    if (mismatch) begin
                        fail_bits <= fail_bits | diff;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec_out;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // Last vector: vec_out parks at 0xF and the verdict is
                    // taken from the count that includes this final sample.
                    if (vec_out == 4'hF) pass <= (err_nxt == 5'd0);
                    else                 vec_out <= vec_out + 4'd1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nand_vector_sequencer.sv
module tb_nand_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] vec_out;
    logic [2:0] dut_y, ref_y;
    logic       busy, done, pass, first_fail_valid;
    logic [4:0] err_count;
    logic [2:0] fail_bits;
    logic [3:0] first_fail_vec;

    logic       start2 = 1'b0;
    logic [3:0] vec2;
    logic [2:0] dut_y2, ref_y2;
    logic       busy2, done2, pass2, ffv2;
    logic [4:0] err2;
    logic [2:0] fb2;
    logic [3:0] ffvec2;

    int mode = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nand_vector_sequencer #(.HOLD_CYCLES(20), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec_out),
        .dut_y(dut_y), .ref_y(ref_y), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_bits(fail_bits),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    nand_vector_sequencer #(.HOLD_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .vec_out(vec2),
        .dut_y(dut_y2), .ref_y(ref_y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_bits(fb2),
        .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
    );

    // Lab gate model: e = 4-input NAND, f = ~(a&b), g = ~(c&d).
    function automatic logic [2:0] model(input logic [3:0] v);
        model = {~&v, ~(v[3] & v[2]), ~(v[1] & v[0])};
    endfunction

    always_comb begin
        ref_y = model(vec_out);
        dut_y = model(vec_out);
        case (mode)
            1: if (vec_out == 4'h5 || vec_out == 4'hA) ref_y[0] = ~ref_y[0];
            2: dut_y = 3'b111;
            3: dut_y = ~model(vec_out);
            default: ;
        endcase
    end

    // Second instance: only vector 7 mismatches, so a late sample shows up
    // as a wrong first_fail_vec.
    always_comb begin
        ref_y2 = model(vec2);
        dut_y2 = model(vec2);
        if (vec2 == 4'h7) dut_y2[1] = ~dut_y2[1];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run and follows it to done. Optional start pulses at run
    // clocks p1/p2 (negative to disable) must have no effect.
    task automatic run20(input bit check_seq, input int p1, input int p2);
        int k;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 400) begin
            if (check_seq) begin
                chk("vec_seq", vec_out, k / 20);
                chk("busy_run", busy, 1);
            end
            start = (k == p1 || k == p2);
            tick();
            start = 1'b0;
            k++;
        end
        chk("run_len", k, 320);
        chk("busy_done", busy, 0);
        chk("vec_done", vec_out, 15);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"}, vec_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_fb"}, fail_bits, 0);
        chk({tag, "_ffvec"}, first_fail_vec, 0);
        chk({tag, "_ffv"}, first_fail_valid, 0);
    endtask

    initial begin
        int k;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("reset");

        // 1: clean run
        mode = 0;
        run20(1'b1, -1, -1);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_count, 0);
        chk("t1_fb", fail_bits, 0);
        chk("t1_ffv", first_fail_valid, 0);

        // 2: model flips g for vectors 5 and A (start held in DONE relaunches)
        mode = 1;
        run20(1'b0, -1, -1);
        chk("t2_err", err_count, 2);
        chk("t2_fb", fail_bits, 3'b001);
        chk("t2_ffvec", first_fail_vec, 5);
        chk("t2_ffv", first_fail_valid, 1);
        chk("t2_pass", pass, 0);

        // 3a: gate stuck at 111 -> mismatches at 3,7,B,C,D,E,F
        mode = 2;
        run20(1'b0, -1, -1);
        chk("t3_err", err_count, 7);
        chk("t3_fb", fail_bits, 3'b111);
        chk("t3_ffvec", first_fail_vec, 3);
        chk("t3_pass", pass, 0);

        // 3b: every vector mismatches
        mode = 3;
        run20(1'b0, -1, -1);
        chk("t3_err16", err_count, 16);
        chk("t3_ffvec0", first_fail_vec, 0);
        chk("t3_ffv0", first_fail_valid, 1);

        // 4: reset at run clock 100
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("t4_vec_at100", vec_out, 5);
        chk("t4_busy_at100", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t4_rst");
        tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_vec", vec_out, 0);
        mode = 0;
        run20(1'b1, -1, -1);
        chk("t4_pass", pass, 1);

        // 5: start pulses during DRIVE ignored; held start in DONE relaunches
        mode = 1;
        run20(1'b1, 10, 150);
        chk("t5_err", err_count, 2);
        mode = 0;
        start = 1'b1;
        tick();
        chk("t5_busy", busy, 1);
        chk("t5_done", done, 0);
        chk("t5_vec", vec_out, 0);
        chk("t5_err_clr", err_count, 0);
        chk("t5_fb_clr", fail_bits, 0);
        chk("t5_ffv_clr", first_fail_valid, 0);
        chk("t5_ffvec_clr", first_fail_vec, 0);
        chk("t5_pass_clr", pass, 0);
        tick();
        start = 1'b0;
        chk("t5_vec_hold", vec_out, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 6: HOLD_CYCLES=2 instance, only vector 7 mismatches
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 64) begin
            chk("t6_vec_seq", vec2, k / 2);
            tick();
            k++;
        end
        chk("t6_run_len", k, 32);
        chk("t6_err", err2, 1);
        chk("t6_ffvec", ffvec2, 7);
        chk("t6_fb", fb2, 3'b010);
        chk("t6_pass", pass2, 0);
        chk("t6_busy", busy2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
